instr_issue_unit: RTL

- Consumer end of the 20-bit instruction fetch interface: samples the fetched instruction, decodes it, executes it on a 4-entry register file, and drives `hold` back to the fetch/PC block to stall it.
- 3-stage pipeline: ID (decode + operand read), EX (ALU), WB (register write).
- Replaces software-inserted nulls with a hardware interlock, or with forwarding when FORWARD=1.

---
 rtl/instr_issue_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_issue_unit.sv
// Three-stage issue/execute unit: ID decodes and reads operands, EX runs the ALU, WB writes a
// 4-entry register file. A RAW hazard against EX either stalls fetch via hold or is bypassed.
module instr_issue_unit #(
   parameter int DATA_W  = 8,
   parameter int FORWARD = 0,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [19:0]           instruction,
   input  logic                  instr_valid,
   output logic                  hold,
   output logic                  wb_en,
   output logic [1:0]            wb_rd,
   output logic [DATA_W-1:0]     wb_data,
   output logic [4*DATA_W-1:0]   reg_dbg,
   output logic                  illegal,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      retire_cnt
);

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_RSV = 3'd3;
   localparam logic [2:0] OP_NOT = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_AND = 3'd7;

   logic [2:0]        id_op;
   logic              id_imm_sel;
   logic [1:0]        id_rd, id_rs;
   logic [DATA_W-1:0] id_imm;
   logic              id_live, id_uses_rs, raw;
   logic              unused_fields;

   logic                   ex_vld_q, ex_vld_d;
   logic [2:0]             ex_op_q, ex_op_d;
   logic [1:0]             ex_rd_q, ex_rd_d;
   logic [DATA_W-1:0]      ex_a_q, ex_a_d, ex_b_q, ex_b_d;
   logic [DATA_W-1:0]      alu_res;
   logic                   wb_en_q, wb_en_d;
   logic [1:0]             wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0]      wb_data_q, wb_data_d;
   logic [3:0][DATA_W-1:0] rf_q, rf_d, byp;
   logic                   illegal_q, illegal_d;
   logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d, retire_cnt_q, retire_cnt_d;

   assign id_op         = instruction[19:17];
   assign id_imm_sel    = instruction[16];
   assign id_rd         = instruction[9:8];
   assign id_rs         = instruction[1:0];
   assign id_imm        = DATA_W'($signed(instruction[7:0]));
   assign unused_fields = ^instruction[15:10];

   // Only real writers are captured into EX, so ex_vld_q alone marks a pending write of ex_rd_q.
   always_comb begin
      id_live    = instr_valid && (id_op != OP_NOP) && (id_op != OP_RSV);
      id_uses_rs = id_live && !id_imm_sel && (id_op != OP_NOT);
      raw        = id_live && ex_vld_q &&
                   ((ex_rd_q == id_rd) || (id_uses_rs && (ex_rd_q == id_rs)));
   end

   assign hold = (FORWARD == 0) ? raw : 1'b0;

   always_comb begin
      case (ex_op_q)
         OP_ADD:  alu_res = ex_a_q + ex_b_q;
         OP_SUB:  alu_res = ex_a_q - ex_b_q;
         OP_NOT:  alu_res = ~ex_a_q;
         OP_XOR:  alu_res = ex_a_q ^ ex_b_q;
         OP_OR:   alu_res = ex_a_q | ex_b_q;
         OP_AND:  alu_res = ex_a_q & ex_b_q;
         default: alu_res = ex_a_q;
      endcase
   end

   // Operand bypass: EX result (forwarding build only) beats WB write-through beats the array.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         byp[i] = rf_q[i];
         if (wb_en_q && (wb_rd_q == 2'(i)))
            byp[i] = wb_data_q;
         if ((FORWARD != 0) && ex_vld_q && (ex_rd_q == 2'(i)))
            byp[i] = alu_res;
      end
   end

   always_comb begin
      ex_vld_d  = id_live && !hold;
      ex_op_d   = id_op;
      ex_rd_d   = id_rd;
      ex_a_d    = byp[id_rd];
      ex_b_d    = id_imm_sel ? id_imm : byp[id_rs];
      wb_en_d   = ex_vld_q;
      wb_rd_d   = ex_rd_q;
      wb_data_d = alu_res;
      rf_d      = rf_q;
      if (wb_en_q)
         rf_d[wb_rd_q] = wb_data_q;
      illegal_d    = illegal_q || (instr_valid && (id_op == OP_RSV));
      stall_cnt_d  = stall_cnt_q;
      if (hold && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      retire_cnt_d = retire_cnt_q;
      if (wb_en_q && !(&retire_cnt_q))
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_vld_q     <= 1'b0;
         ex_op_q      <= '0;
         ex_rd_q      <= '0;
         ex_a_q       <= '0;
         ex_b_q       <= '0;
         wb_en_q      <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         rf_q         <= '0;
         illegal_q    <= 1'b0;
         stall_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         ex_vld_q     <= ex_vld_d;
         ex_op_q      <= ex_op_d;
         ex_rd_q      <= ex_rd_d;
         ex_a_q       <= ex_a_d;
         ex_b_q       <= ex_b_d;
         wb_en_q      <= wb_en_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         rf_q         <= rf_d;
         illegal_q    <= illegal_d;
         stall_cnt_q  <= stall_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign wb_en      = wb_en_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign reg_dbg    = rf_q;
   assign illegal    = illegal_q;
   assign stall_cnt  = stall_cnt_q;
   assign retire_cnt = retire_cnt_q;

endmodule
